// File: rtl/nbit_updown_counter_pkg.sv
// Shared constants and the count-limit helper for the up/down counter family.
package nbit_updown_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam bit   MODE_WRAP = 1'b0;
   localparam bit   MODE_SAT  = 1'b1;

   // Largest legal count (MOD-1), with MOD forced into 2..2**width.
   function automatic logic [32:0] count_limit(input int unsigned width,
                                               input longint unsigned modulus);
      longint unsigned cap;
      longint unsigned m;
      cap = 64'd1 << width;
      m   = modulus;
      if (m > cap) m = cap;
      if (m < 64'd2) m = 64'd2;
      return 33'(m - 64'd1);
   endfunction

endpackage

// File: rtl/nbit_updown_counter_next.sv
// Combinational next-count, terminal-count and wrap-event logic.
module counter_next
   import nbit_updown_counter_pkg::*;
#(
   parameter int              WIDTH = 4,
   parameter longint unsigned MOD   = 64'd1 << WIDTH,
   parameter bit              SAT   = MODE_WRAP
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             up,
   input  logic             en,
   output logic [WIDTH-1:0] cnt_next,
   output logic             tc,
   output logic             wrap_evt
);

   localparam logic [32:0]    LIMIT_FULL = count_limit(WIDTH, MOD);
   localparam logic [WIDTH:0] LIMIT      = LIMIT_FULL[WIDTH:0];
   localparam logic [WIDTH:0] ONE        = 1;

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] sum_ext;
   logic           at_term;
   logic           unused_msb;

   // The extra top bit keeps the limit compare and +/-1 free of truncation.
   always_comb begin
      cnt_ext  = {1'b0, cnt};
      at_term  = (up == DIR_UP) ? (cnt_ext == LIMIT) : (cnt_ext == '0);
      tc       = en & at_term;
      wrap_evt = tc & (SAT == MODE_WRAP);
      sum_ext  = cnt_ext;
      if (en) begin
         if (at_term)
            sum_ext = (SAT == MODE_SAT) ? cnt_ext : ((up == DIR_UP) ? '0 : LIMIT);
         else if (up == DIR_UP)
            sum_ext = cnt_ext + ONE;
         else
            sum_ext = cnt_ext - ONE;
      end
      cnt_next = sum_ext[WIDTH-1:0];
   end

   assign unused_msb = sum_ext[WIDTH];

endmodule

// File: rtl/nbit_updown_counter.sv
// Modulo/saturating up/down counter: state registers, priority mux and
// reset-release synchroniser around the combinational next-count block.
module nbit_updown_counter
   import nbit_updown_counter_pkg::*;
#(
   parameter int              WIDTH = 4,
   parameter longint unsigned MOD   = 64'd1 << WIDTH,
   parameter bit              SAT   = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [32:0]    LIMIT_FULL = count_limit(WIDTH, MOD);
   localparam logic [WIDTH:0] LIMIT      = LIMIT_FULL[WIDTH:0];

   logic [1:0]       rel_q, rel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] load_clamped;
   logic             wrap_evt;
   logic             run;

   counter_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD),
      .SAT   (SAT)
   ) u_next (
      .cnt      (out_q),
      .up       (up),
      .en       (en),
      .cnt_next (cnt_next),
      .tc       (tc),
      .wrap_evt (wrap_evt)
   );

   // Updates are allowed once the release has reached the synchroniser,
   // so the first count lands on the second edge after rst rises.
   assign run = |rel_q;

   always_comb begin
      rel_d        = {rel_q[0], 1'b1};
      load_clamped = ({1'b0, load_val} > LIMIT) ? LIMIT[WIDTH-1:0] : load_val;
      out_d        = out_q;
      wrap_d       = 1'b0;
      ovf_d        = ovf_q;
      if (run) begin
         if (clr) begin
            out_d = '0;
            ovf_d = 1'b0;
         end else if (load) begin
            out_d = load_clamped;
         end else begin
            out_d  = cnt_next;
            wrap_d = wrap_evt;
            if (tc) ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rel_q  <= '0;
         out_q  <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         rel_q  <= rel_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out  = out_q;
   assign wrap = wrap_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_nbit_updown_counter.sv
// Randomised and directed bench for nbit_updown_counter against an
// arithmetic reference model (modulo / clamp rules, not the RTL structure).
module tb_nbit_updown_counter;

   typedef struct {
      int o;
      bit w;
      bit v;
   } st_t;

   logic clk;
   logic rst;

   logic       en_a, up_a, clr_a, load_a;
   logic [3:0] lv_a, out_a;
   logic       tc_a, wrap_a, ovf_a;

   logic       en_b, up_b, clr_b, load_b;
   logic [3:0] lv_b, out_b;
   logic       tc_b, wrap_b, ovf_b;

   logic       en_c, up_c, clr_c, load_c;
   logic [3:0] lv_c, out_c;
   logic       tc_c, wrap_c, ovf_c;

   logic       en_l, clr_l, clr_h;
   logic [3:0] out_l, out_h;
   logic       tc_l;
   logic       unused_tc_h, unused_wrap_l, unused_wrap_h, unused_ovf_l, unused_ovf_h;

   int   n_checks;
   int   n_fail;
   int   rel_edges;
   st_t  ma, mb, mc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   nbit_updown_counter #(.WIDTH(4), .MOD(16), .SAT(1'b0)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a),
      .load_val(lv_a), .out(out_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

   nbit_updown_counter #(.WIDTH(4), .MOD(10), .SAT(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .up(up_b), .clr(clr_b), .load(load_b),
      .load_val(lv_b), .out(out_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b));

   nbit_updown_counter #(.WIDTH(4), .MOD(10), .SAT(1'b1)) u_c (
      .clk(clk), .rst(rst), .en(en_c), .up(up_c), .clr(clr_c), .load(load_c),
      .load_val(lv_c), .out(out_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c));

   nbit_updown_counter #(.WIDTH(4), .MOD(16), .SAT(1'b0)) u_lo (
      .clk(clk), .rst(rst), .en(en_l), .up(1'b1), .clr(clr_l), .load(1'b0),
      .load_val(4'd0), .out(out_l), .tc(tc_l), .wrap(unused_wrap_l), .ovf(unused_ovf_l));

   nbit_updown_counter #(.WIDTH(4), .MOD(16), .SAT(1'b0)) u_hi (
      .clk(clk), .rst(rst), .en(tc_l), .up(1'b1), .clr(clr_h), .load(1'b0),
      .load_val(4'd0), .out(out_h), .tc(unused_tc_h), .wrap(unused_wrap_h), .ovf(unused_ovf_h));

   function automatic st_t ref_step(st_t s, bit clr, bit load, int lv, bit en, bit up,
                                    int mod, bit sat);
      st_t n;
      bit  hit;
      n   = s;
      n.w = 1'b0;
      if (clr) begin
         n.o = 0;
         n.v = 1'b0;
      end else if (load) begin
         n.o = (lv >= mod) ? mod - 1 : lv;
      end else if (en) begin
         hit = up ? (s.o == mod - 1) : (s.o == 0);
         if (hit) n.v = 1'b1;
         if (up) n.o = sat ? ((s.o + 1 > mod - 1) ? mod - 1 : s.o + 1) : (s.o + 1) % mod;
         else    n.o = sat ? ((s.o - 1 < 0) ? 0 : s.o - 1) : (s.o - 1 + mod) % mod;
         n.w = hit && !sat;
      end
      return n;
   endfunction

   function automatic bit ref_tc(int o, bit en, bit up, int mod);
      return en && (up ? (o == mod - 1) : (o == 0));
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      if (rst && rel_edges >= 1) begin
         ma = ref_step(ma, clr_a, load_a, int'(lv_a), en_a, up_a, 16, 1'b0);
         mb = ref_step(mb, clr_b, load_b, int'(lv_b), en_b, up_b, 10, 1'b0);
         mc = ref_step(mc, clr_c, load_c, int'(lv_c), en_c, up_c, 10, 1'b1);
      end else begin
         ma.w = 1'b0;
         mb.w = 1'b0;
         mc.w = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst) rel_edges++;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "_a_out"}, 64'(out_a), 64'(ma.o));
      check_val({tag, "_a_wrap"}, 64'(wrap_a), 64'(ma.w));
      check_val({tag, "_a_ovf"}, 64'(ovf_a), 64'(ma.v));
      check_val({tag, "_b_out"}, 64'(out_b), 64'(mb.o));
      check_val({tag, "_b_wrap"}, 64'(wrap_b), 64'(mb.w));
      check_val({tag, "_b_ovf"}, 64'(ovf_b), 64'(mb.v));
      check_val({tag, "_c_out"}, 64'(out_c), 64'(mc.o));
      check_val({tag, "_c_wrap"}, 64'(wrap_c), 64'(mc.w));
      check_val({tag, "_c_ovf"}, 64'(ovf_c), 64'(mc.v));
   endtask

   task automatic reset_models();
      ma = '{0, 1'b0, 1'b0};
      mb = '{0, 1'b0, 1'b0};
      mc = '{0, 1'b0, 1'b0};
      rel_edges = 0;
   endtask

   initial begin
      int exp_o[5];
      int exp_v[5];
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      {en_a, up_a, clr_a, load_a, lv_a} = '0;
      {en_b, up_b, clr_b, load_b, lv_b} = '0;
      {en_c, up_c, clr_c, load_c, lv_c} = '0;
      {en_l, clr_l, clr_h} = '0;
      reset_models();

      // Reset state and tc behaviour while held in reset
      #2;
      check_all("rst");
      check_val("rst_tc_idle", 64'(tc_a), 64'(0));
      en_a = 1'b1; up_a = 1'b0; #1;
      check_val("rst_tc_down", 64'(tc_a), 64'(1));
      up_a = 1'b1; #1;
      check_val("rst_tc_up", 64'(tc_a), 64'(0));
      en_a = 1'b0;
      tick();
      tick();
      check_all("rst_hold");
      rst = 1'b1;
      tick();
      tick();

      // Full-range up count with wrap on MOD=16
      en_a = 1'b1; up_a = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         check_val("a_tc", 64'(tc_a), 64'(ref_tc(ma.o, en_a, up_a, 16)));
         if (k == 15) check_val("a_tc15", 64'(tc_a), 64'(1));
         tick();
         check_all("a_run");
         $display("a step %0d out=%0d wrap=%0d ovf=%0d", k, out_a, wrap_a, ovf_a);
      end
      check_val("a_end_out", 64'(out_a), 64'(0));
      check_val("a_end_wrap", 64'(wrap_a), 64'(1));
      check_val("a_end_ovf", 64'(ovf_a), 64'(1));
      tick();
      check_val("a_wrap_once", 64'(wrap_a), 64'(0));
      check_val("a_ovf_sticky", 64'(ovf_a), 64'(1));
      en_a = 1'b0;

      // Saturating up count from 7 on MOD=10
      load_c = 1'b1; lv_c = 4'd7;
      tick();
      check_val("c_load7", 64'(out_c), 64'(7));
      load_c = 1'b0; en_c = 1'b1; up_c = 1'b1;
      exp_o = '{8, 9, 9, 9, 9};
      exp_v = '{0, 0, 1, 1, 1};
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val("c_sat_out", 64'(out_c), 64'(exp_o[k]));
         check_val("c_sat_ovf", 64'(ovf_c), 64'(exp_v[k]));
         check_val("c_sat_wrap", 64'(wrap_c), 64'(0));
         check_all("c_run");
         $display("c step %0d out=%0d ovf=%0d", k, out_c, ovf_c);
      end
      en_c = 1'b0;

      // Down-wrap from 0 on MOD=10, then random traffic
      en_b = 1'b1; up_b = 1'b0; #1;
      check_val("b_tc_down0", 64'(tc_b), 64'(1));
      tick();
      check_val("b_down_out", 64'(out_b), 64'(9));
      check_val("b_down_wrap", 64'(wrap_b), 64'(1));
      for (int k = 0; k < 100; k++) begin
         en_b   = 1'($urandom % 2);
         up_b   = 1'($urandom % 2);
         clr_b  = ($urandom % 16) == 0;
         load_b = ($urandom % 8) == 0;
         lv_b   = 4'($urandom % 16);
         #1;
         check_val("b_tc", 64'(tc_b), 64'(ref_tc(mb.o, en_b, up_b, 10)));
         tick();
         check_all("b_rand");
         check_val("b_range", 64'(out_b < 4'd10), 64'(1));
         $display("b rand %0d en=%0d up=%0d clr=%0d ld=%0d lv=%0d out=%0d", k, en_b, up_b,
                  clr_b, load_b, lv_b, out_b);
      end
      {en_b, up_b, clr_b, load_b, lv_b} = '0;

      // Load clamp, then clr beating load and en
      load_b = 1'b1; lv_b = 4'd12;
      tick();
      check_val("b_clamp", 64'(out_b), 64'(9));
      load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
      tick();
      check_val("b_wrap_ovf", 64'(ovf_b), 64'(1));
      clr_b = 1'b1; load_b = 1'b1; lv_b = 4'd5;
      tick();
      check_val("b_clr_out", 64'(out_b), 64'(0));
      check_val("b_clr_ovf", 64'(ovf_b), 64'(0));
      check_all("b_clr");
      {en_b, up_b, clr_b, load_b, lv_b} = '0;

      // Asynchronous reset mid-count, pending load abandoned, delayed restart
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      check_val("e_at6", 64'(out_a), 64'(6));
      load_a = 1'b1; lv_a = 4'd3;
      #2;
      rst = 1'b0;
      reset_models();
      #1;
      check_val("e_async_out", 64'(out_a), 64'(0));
      check_val("e_async_ovf", 64'(ovf_a), 64'(0));
      tick();
      check_val("e_load_dropped", 64'(out_a), 64'(0));
      load_a = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      check_val("e_first_edge", 64'(out_a), 64'(0));
      tick();
      check_val("e_second_edge", 64'(out_a), 64'(1));
      check_all("e_restart");
      en_a = 1'b0; up_a = 1'b0;

      // Two cascaded counters form an 8-bit modulo-256 counter
      clr_l = 1'b1; clr_h = 1'b1;
      tick();
      clr_l = 1'b0; clr_h = 1'b0;
      check_val("f_clr", 64'({out_h, out_l}), 64'(0));
      en_l = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         check_val("f_cascade", 64'({out_h, out_l}), 64'(i % 256));
      end
      $display("cascade final value=%0d", {out_h, out_l});
      en_l = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nbit_updown_counter.md
NBIT_UPDOWN_COUNTER -- requirements
Module: nbit_updown_counter

Interface
REQ-001 Parameter WIDTH SHALL be declared with default 4, meaning counter width in bits (legal range 1..32).
REQ-002 Parameter MOD SHALL be declared with default 2**WIDTH, meaning count modulus (legal range 2..2**WIDTH); count range is 0..MOD-1.
REQ-003 Parameter SAT SHALL be declared with default 0, meaning 0 = wrap at limits and 1 = saturate at limits.
REQ-004 Port clk SHALL be an input of width 1: single clock, all state updates on its rising edge.
REQ-005 Port rst SHALL be an input of width 1: asynchronous, active-low reset.
REQ-006 Port en SHALL be an input of width 1: count enable.
REQ-007 Port up SHALL be an input of width 1: direction, 1 = increment and 0 = decrement.
REQ-008 Port clr SHALL be an input of width 1: synchronous clear.
REQ-009 Port load SHALL be an input of width 1: synchronous parallel load.
REQ-010 Port load_val SHALL be an input of width WIDTH: value to load.
REQ-011 Port out SHALL be an output of width WIDTH: current count, registered.
REQ-012 Port tc SHALL be an output of width 1: terminal count, combinational.
REQ-013 Port wrap SHALL be an output of width 1: registered one-cycle wrap pulse.
REQ-014 Port ovf SHALL be an output of width 1: sticky limit-hit flag, registered.

Function
REQ-015 Per-cycle priority SHALL be clr > load > en > hold.
REQ-016 On clr=1, out SHALL become 0 on the next edge, and ovf and wrap SHALL become 0.
REQ-017 On load=1 (clr=0), out SHALL become load_val; if load_val >= MOD, out SHALL become MOD-1 instead.
REQ-018 On load=1, ovf SHALL be unchanged and wrap SHALL be 0.
REQ-019 With en=1 and up=1, out SHALL increment by 1 per cycle; latency is one edge from en to the new count.
REQ-020 With en=1 and up=0, out SHALL decrement by 1 per cycle.
REQ-021 Terminal state SHALL be out==MOD-1 when up=1 and out==0 when up=0.
REQ-022 tc SHALL equal en AND (out is at the terminal state for the current up value), so that cascaded instances can use it as a carry/borrow enable.
REQ-023 With SAT=0, a count from the terminal state SHALL wrap: MOD-1 goes to 0 when counting up, and 0 goes to MOD-1 when counting down.
REQ-024 With SAT=0, wrap SHALL be 1 for exactly the cycle after each wrap edge.
REQ-025 With SAT=1, a count from the terminal state SHALL hold out unchanged, and wrap SHALL stay 0.
REQ-026 ovf SHALL set to 1 on any edge where en=1 and tc=1 (a wrap or a blocked saturation) and clr=0 and load=0.
REQ-027 Once set, ovf SHALL hold until clr or reset.
REQ-028 A direction change mid-count SHALL take effect on the same edge, with no dead cycle.
REQ-029 When MOD is not a power of two, out SHALL never present a value >= MOD under any input sequence.
REQ-030 All arithmetic SHALL be computed in WIDTH+1 bits internally, with no silent truncation before the limit compare.

Reset
REQ-031 While rst=0, out, wrap and ovf SHALL be 0 immediately, independent of clk.
REQ-032 tc SHALL then follow from out=0: it is 1 only if en=1 and up=0.
REQ-033 Reset deassertion SHALL be used synchronously inside the block, via a two-flop release synchroniser on clk.
REQ-034 The first count SHALL occur no earlier than the second rising edge after rst rises.
REQ-035 Reset asserted mid-count SHALL abandon any pending load or clear.

Structure
REQ-036 A shared package SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0, the mode constants MODE_WRAP=0 and MODE_SAT=1, and a function computing the legal MOD-1 limit for a given WIDTH.
REQ-037 One sub-module, counter_next, SHALL compute the next count, tc and wrap-event combinationally from out, up, en and the parameters.
REQ-038 The top level SHALL hold only registers, priority muxing and the reset synchroniser.
REQ-039 The design SHALL be fully synchronous to clk: no output-derived clocks and no ripple clocking between bits.

Verification
REQ-040 A bench SHALL cover: WIDTH=4, MOD=16, SAT=0; reset, then en=1, up=1 for 17 cycles -> out runs 0..15 then 0; tc=1 at out=15; wrap=1 the cycle out=0; ovf=1 afterwards.
REQ-041 A bench SHALL cover: WIDTH=4, MOD=10, SAT=0; up=0 from out=0 -> out=9 next edge, wrap pulse, out never >= 10 over 100 random en/up cycles.
REQ-042 A bench SHALL cover: WIDTH=4, MOD=10, SAT=1; load 7, up=1 for 5 cycles -> out 8,9,9,9,9; wrap stays 0; ovf=1 from the first blocked cycle.
REQ-043 A bench SHALL cover: load_val=12 with MOD=10 -> out=9; clr and load both asserted with en=1 -> out=0 and ovf=0.
REQ-044 A bench SHALL cover: rst driven low between clock edges at out=6 -> out=0 without waiting for an edge; rst released -> no count on the first edge, count 1 on the second.
REQ-045 A bench SHALL cover: two WIDTH=4 instances cascaded (upper en = lower tc) counting up for 300 cycles -> combined 8-bit value equals cycle count mod 256.
